gps_llki_key_loader: RTL

LLKI discrete-interface master that sits directly upstream of the GPS mock-TSS wrapper and drives its llkid_* key port. Software writes KEY_WORDS 64-bit key words into a local buffer, then issues load or clear commands. The block streams the words over the valid/ready key handshake and waits for key-complete. For a clear, it issues clear-key and waits for the ack. It reports busy/done/error status back to the register block.

---
 rtl/gps_llki_key_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gps_llki_key_loader.sv
// gps_llki_key_loader: LLKI discrete-interface master for the GPS mock-TSS.
// Software fills a KEY_WORDS x 64-bit key buffer, then pulses load_req to
// stream the words to the TSS, or clear_req to have the TSS clear its key.
// Optional build macro: GPS_KEY_LOADER_ZEROIZE_EN (zero the buffer after a
// successful load). The default build leaves the buffer intact after a load.
//
// Key handshake: llkid_key_valid and llkid_key_data are registered and held
// stable until a cycle with valid && ready, which is the one and only
// transfer of that word; valid never depends combinationally on ready.
module gps_llki_key_loader #(
  parameter int KEY_WORDS      = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AW             = $clog2(KEY_WORDS)
) (
  input  logic          sys_clk_50,
  input  logic          async_rst_n,
  input  logic          key_wr_en,
  input  logic [AW-1:0] key_wr_addr,
  input  logic [63:0]   key_wr_data,
  input  logic          load_req,
  input  logic          clear_req,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [63:0]   llkid_key_data,
  output logic          llkid_key_valid,
  input  logic          llkid_key_ready,
  input  logic          llkid_key_complete,
  output logic          llkid_clear_key,
  input  logic          llkid_clear_key_ack,
  output logic [2:0]    state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_CMP = 3'd2,
    CLEAR    = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   tmo;
  logic [63:0]     key_buf [KEY_WORDS];

  logic            wr_ok;
  logic            wr_bad;
  logic            tmo_hit;
  logic [CW-1:0]   tmo_next;
  logic            last_word;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Buffer writes land only while idle and in range; anything else is flagged.
  assign wr_ok     = key_wr_en && (state == IDLE) && (int'(key_wr_addr) < KEY_WORDS);
  assign wr_bad    = key_wr_en && !wr_ok;
  assign tmo_hit   = (tmo == CW'(TIMEOUT_CYCLES - 1));
  assign tmo_next  = tmo_hit ? tmo : tmo + CW'(1);
  assign last_word = (idx == AW'(KEY_WORDS - 1));

  // Command FSM, key buffer and all registered outputs.
  always_ff @(posedge sys_clk_50 or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      tmo             <= '0;
      llkid_key_valid <= 1'b0;
      llkid_key_data  <= '0;
      llkid_clear_key <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      for (int i = 0; i < KEY_WORDS; i++) key_buf[i] <= '0;
    end else begin
      if (wr_ok) key_buf[key_wr_addr] <= key_wr_data;

      case (state)
        IDLE: begin
          // Clear takes priority over a simultaneous load.
          if (clear_req) begin
            state           <= CLEAR;
            llkid_clear_key <= 1'b1;
            tmo             <= '0;
            done            <= 1'b0;
            error           <= 1'b0;
          end else if (load_req) begin
            state           <= LOAD;
            idx             <= '0;
            tmo             <= '0;
            llkid_key_valid <= 1'b1;
            llkid_key_data  <= key_buf[0];
            done            <= 1'b0;
            error           <= 1'b0;
          end
        end

        LOAD: begin
          if (llkid_key_valid && llkid_key_ready) begin
            tmo <= '0;
            if (last_word) begin
              llkid_key_valid <= 1'b0;
              state           <= WAIT_CMP;
            end else begin
              idx            <= idx + AW'(1);
              llkid_key_data <= key_buf[idx + AW'(1)];
            end
          end else if (tmo_hit) begin
            error           <= 1'b1;
            llkid_key_valid <= 1'b0;
            state           <= IDLE;
          end else begin
            tmo <= tmo_next;
          end
        end

        WAIT_CMP: begin
          if (llkid_key_complete) begin
            done  <= 1'b1;
            state <= IDLE;
`ifdef GPS_KEY_LOADER_ZEROIZE_EN
            for (int i = 0; i < KEY_WORDS; i++) key_buf[i] <= '0;
`endif
          end else if (tmo_hit) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            tmo <= tmo_next;
          end
        end

        CLEAR: begin
          if (llkid_clear_key_ack) begin
            llkid_clear_key <= 1'b0;
            tmo             <= '0;
            state           <= WAIT_ACK;
          end else if (tmo_hit) begin
            error           <= 1'b1;
            llkid_clear_key <= 1'b0;
            state           <= IDLE;
          end else begin
            tmo <= tmo_next;
          end
        end

        WAIT_ACK: begin
          if (!llkid_clear_key_ack) begin
            done  <= 1'b1;
            state <= IDLE;
            for (int i = 0; i < KEY_WORDS; i++) key_buf[i] <= '0;
          end else if (tmo_hit) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            tmo <= tmo_next;
          end
        end

        default: state <= IDLE;
      endcase

      // A dropped write always flags, even on the edge a command is accepted.
      if (wr_bad) error <= 1'b1;
    end
  end

endmodule
